crossbar_sequencer: RTL

Frame-level controller for the adder-tree → output-module path. It multiplexes the KERNEL_SIZE adder-tree AXI-Stream outputs onto one registered master stream. Lane selection is round-robin, in either strict or skip-empty order. The block counts beats into rows and frames, marks row ends (tlast) and frame start (tuser), and reports frame completion. It replaces the free-running combinational mux with a bounded, software-started frame transfer.

---
 rtl/crossbar_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/crossbar_sequencer.sv
// crossbar_sequencer
// Frame-level controller that round-robins KERNEL_SIZE adder-tree lanes onto one
// registered AXI-Stream master. It runs a single frame of ROW_LEN*NUM_ROWS beats
// per cfg_start. Each row end is marked with tlast and the frame start with tuser.
// A one-cycle done pulse fires once the last beat has left the output register.

module crossbar_sequencer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 18,
    parameter int ROW_LEN     = 64,
    parameter int NUM_ROWS    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic                             cfg_strict,
    input  logic [KERNEL_SIZE-1:0]           s_axis_tvalid,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] s_axis_tdata,
    output logic [KERNEL_SIZE-1:0]           s_axis_tready,
    output logic                             m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    input  logic                             m_axis_tready,
    output logic                             busy,
    output logic                             done
);

    localparam int PTR_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_strict;
    logic                  r_first;
    logic [PTR_W-1:0]      r_ptr;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_mValid;
    logic [DATA_WIDTH-1:0] r_mData;
    logic                  r_mLast;
    logic                  r_mUser;
    logic                  r_busy;
    logic                  r_done;

    logic                   w_slotFree;
    logic                   w_laneValid;
    logic [DATA_WIDTH-1:0]  w_laneData;
    logic [KERNEL_SIZE-1:0] w_readyVec;
    logic                   w_accept;
    logic [PTR_W-1:0]       w_ptrNext;
    logic                   w_lastBeat;

    // Lane selection and handshake decode; ready depends only on registered state and m_axis_tready
    always_comb begin
        w_slotFree  = !r_mValid || m_axis_tready;
        w_laneValid = 1'b0;
        w_laneData  = '0;
        w_readyVec  = '0;
        for (int g = 0; g < KERNEL_SIZE; g++) begin
            if (r_ptr == PTR_W'(g)) begin
                w_laneValid = s_axis_tvalid[g];
                w_laneData  = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
                if (r_state == RUN && w_slotFree) begin
                    w_readyVec[g] = 1'b1;
                end
            end
        end
        w_accept   = (r_state == RUN) && w_slotFree && w_laneValid;
        w_ptrNext  = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        w_lastBeat = (r_col == COL_LAST) && (r_row == ROW_LAST);
    end

    // Frame FSM, position counters and the registered master-side output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_strict <= 1'b0;
            r_first  <= 1'b0;
            r_ptr    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_mValid <= 1'b0;
            r_mData  <= '0;
            r_mLast  <= 1'b0;
            r_mUser  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mValid <= 1'b1;
                r_mData  <= w_laneData;
                r_mLast  <= (r_col == COL_LAST);
                r_mUser  <= r_first && (r_col == '0) && (r_row == '0);
            end else if (m_axis_tready) begin
                r_mValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (cfg_start) begin
                        r_strict <= cfg_strict;
                        r_first  <= 1'b1;
                        r_ptr    <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_ptr   <= w_ptrNext;
                        r_first <= 1'b0;
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_lastBeat) begin
                            r_state <= DRAIN;
                        end
                    end else if (!w_laneValid && !r_strict) begin
                        r_ptr <= w_ptrNext;
                    end
                end
                DRAIN: begin
                    if (r_mValid && m_axis_tready) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_readyVec;
    assign m_axis_tvalid = r_mValid;
    assign m_axis_tdata  = r_mData;
    assign m_axis_tlast  = r_mLast;
    assign m_axis_tuser  = r_mUser;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
